// File: rtl/hack_arith_pkg.sv
// hack_arith_pkg: shared arithmetic defaults and parameter legality check
package hack_arith_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_STAGES = 4;
  function automatic bit stages_divide(input int w, input int s);
    return s > 0 && w % s == 0;
  endfunction
endpackage

// File: rtl/adder_chunk.sv
// adder_chunk: W-bit ripple-carry adder exposing carry out and carry into the MSB
module adder_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_ci,
  output logic [W-1:0] o_s,
  output logic         o_co,
  output logic         o_cm
);
  logic [W:0] w_c;
  always_comb begin
    w_c = '0;
    o_s = '0;
    w_c[0] = i_ci;
    for (int i = 0; i < W; i++) begin
      o_s[i] = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
  end
  assign o_co = w_c[W];
  assign o_cm = w_c[W-1];
endmodule

// File: rtl/adder_pipe.sv
// adder_pipe: pipelined add/subtract, one CHUNK of bits per stage, valid/ready at both ends
module adder_pipe import hack_arith_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zr,
  output logic             ng
);
  localparam int CHUNK = WIDTH / STAGES;
  localparam int L = STAGES - 1;
  if (!stages_divide(WIDTH, STAGES)) begin : g_chk
    $error("adder_pipe: STAGES must divide WIDTH");
  end
  logic             r_v  [STAGES];
  logic [WIDTH-1:0] r_s  [STAGES];
  logic [WIDTH-1:0] r_a  [STAGES];
  logic [WIDTH-1:0] r_b  [STAGES];
  logic             r_c  [STAGES];
  logic             r_cm [STAGES];
  logic             w_vi [STAGES];
  logic [WIDTH-1:0] w_si [STAGES];
  logic [WIDTH-1:0] w_ai [STAGES];
  logic [WIDTH-1:0] w_bi [STAGES];
  logic [WIDTH-1:0] w_ns [STAGES];
  logic             w_ci [STAGES];
  logic [CHUNK-1:0] w_cs [STAGES];
  logic             w_co [STAGES];
  logic             w_cm [STAGES];
  logic [STAGES:0]  w_adv;
  always_comb begin
    w_adv = '0;
    w_adv[STAGES] = out_ready;
    for (int k = L; k >= 0; k--) w_adv[k] = !r_v[k] || w_adv[k+1];
  end
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_in
      assign w_vi[k] = in_valid;
      assign w_si[k] = '0;
      assign w_ai[k] = x;
      assign w_bi[k] = sub ? ~y : y;
      assign w_ci[k] = sub | cin;
    end else begin : g_link
      assign w_vi[k] = r_v[k-1];
      assign w_si[k] = r_s[k-1];
      assign w_ai[k] = r_a[k-1];
      assign w_bi[k] = r_b[k-1];
      assign w_ci[k] = r_c[k-1];
    end
    adder_chunk #(.W(CHUNK)) u_chunk (
      .i_a  (w_ai[k][k*CHUNK +: CHUNK]),
      .i_b  (w_bi[k][k*CHUNK +: CHUNK]),
      .i_ci (w_ci[k]),
      .o_s  (w_cs[k]),
      .o_co (w_co[k]),
      .o_cm (w_cm[k])
    );
    // upstream sum bits at and above this chunk are always zero, so OR merges cleanly
    assign w_ns[k] = w_si[k] | (WIDTH'(w_cs[k]) << (k * CHUNK));
  end
  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES; k++) begin
      if (reset) begin
        r_v[k] <= 1'b0;
        r_s[k] <= '0;
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_c[k] <= 1'b0;
        r_cm[k] <= 1'b0;
      end else if (w_adv[k]) begin
        r_v[k] <= w_vi[k];
        r_s[k] <= w_ns[k];
        r_a[k] <= w_ai[k];
        r_b[k] <= w_bi[k];
        r_c[k] <= w_co[k];
        r_cm[k] <= w_cm[k];
      end
    end
  end
  assign in_ready = w_adv[0];
  assign out_valid = r_v[L];
  assign sum = r_s[L];
  assign cout = r_c[L];
  assign ovf = r_cm[L] ^ r_c[L];
  assign zr = out_valid & ~|r_s[L];
  assign ng = r_s[L][WIDTH-1];
endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: vector table, scoreboarded random traffic, flow-control corners and a 32-bit depth sweep
module tb_adder_pipe;
  typedef struct packed {logic [31:0] s; logic c, o, z, n;} res_t;
  typedef struct {logic [15:0] x, y; logic ci, sb; res_t e;} vec_t;
  logic clk = 0, reset = 1;
  logic in_valid = 0, cin = 0, sub = 0, out_ready = 1;
  logic [15:0] x = 0, y = 0;
  logic in_ready, out_valid, cout, ovf, zr, ng;
  logic [15:0] sum;
  logic b_valid = 0, b_cin = 0, b_sub = 0;
  logic [31:0] b_x = 0, b_y = 0;
  logic b_ir [3], b_ov [3], b_co [3], b_of [3], b_zr [3], b_ng [3];
  logic [31:0] b_sum [3];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  adder_pipe #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf), .zr(zr), .ng(ng)
  );
  for (genvar g = 0; g < 3; g++) begin : g_sw
    adder_pipe #(.WIDTH(32), .STAGES(g == 0 ? 1 : g == 1 ? 2 : 8)) u_sw (
      .clk(clk), .reset(reset), .in_valid(b_valid), .in_ready(b_ir[g]), .x(b_x), .y(b_y),
      .cin(b_cin), .sub(b_sub), .out_valid(b_ov[g]), .out_ready(1'b1), .sum(b_sum[g]),
      .cout(b_co[g]), .ovf(b_of[g]), .zr(b_zr[g]), .ng(b_ng[g])
    );
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Reference: plain wide arithmetic, signed overflow from operand/result signs
  function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic sb);
    logic [31:0] m;
    logic [32:0] t;
    logic sa, sbb, sr;
    res_t r;
    m = (w == 32) ? 32'hFFFF_FFFF : (32'd1 << w) - 32'd1;
    a = a & m;
    b = b & m;
    t = sb ? {1'b0, a} + {1'b0, ~b & m} + 33'd1 : {1'b0, a} + {1'b0, b} + {32'd0, ci};
    r.s = t[31:0] & m;
    r.c = t[w];
    sa = a[w-1];
    sbb = b[w-1];
    sr = r.s[w-1];
    r.o = sb ? (sa != sbb && sr != sa) : (sa == sbb && sr != sa);
    r.z = (r.s == 0);
    r.n = sr;
    return r;
  endfunction
  function automatic res_t got16();
    res_t r;
    r.s = {16'h0, sum};
    r.c = cout; r.o = ovf; r.z = zr; r.n = ng;
    return r;
  endfunction
  function automatic res_t got32(input int g);
    res_t r;
    r.s = b_sum[g];
    r.c = b_co[g]; r.o = b_of[g]; r.z = b_zr[g]; r.n = b_ng[g];
    return r;
  endfunction
  function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic ci,
                              input logic sb, input logic [15:0] s, input logic c,
                              input logic o, input logic z, input logic n);
    vec_t v;
    v.x = a; v.y = b; v.ci = ci; v.sb = sb;
    v.e.s = {16'h0, s}; v.e.c = c; v.e.o = o; v.e.z = z; v.e.n = n;
    return v;
  endfunction
  initial begin
    vec_t tv [8];
    res_t q [$];
    res_t e4 [6];
    res_t hr [400];
    logic hv [400];
    int lat, i4, got, blk, t0, t1, seen;
    tv[0] = mk(16'h0008, 16'h0008, 0, 0, 16'h0010, 0, 0, 0, 0);
    tv[1] = mk(16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, 1, 0);
    tv[2] = mk(16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, 0, 1);
    tv[3] = mk(16'h0005, 16'h0007, 1, 1, 16'hFFFE, 0, 0, 0, 1);
    tv[4] = mk(16'h0007, 16'h0007, 0, 1, 16'h0000, 1, 0, 1, 0);
    tv[5] = mk(16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1, 0, 0);
    tv[6] = mk(16'hFFFF, 16'hFFFF, 1, 0, 16'hFFFF, 1, 0, 0, 1);
    tv[7] = mk(16'h1234, 16'h0F0F, 1, 0, 16'h2144, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_ready", 64'(in_ready), 1);
    chk("rst_fields", 64'({sum, cout, ovf, zr, ng}), 0);
    for (int v = 0; v < 8; v++) begin
      @(posedge clk);
      #1 in_valid = 1; x = tv[v].x; y = tv[v].y; cin = tv[v].ci; sub = tv[v].sb;
      lat = 0;
      do begin
        @(posedge clk);
        #1 lat++;
        in_valid = 0;
      end while (!out_valid && lat < 20);
      chk($sformatf("vec%0d_latency", v), 64'(lat), 4);
      chk($sformatf("vec%0d_result", v), 64'(got16()), 64'(tv[v].e));
      @(posedge clk);
      #1 chk($sformatf("vec%0d_bubble", v), 64'({out_valid, zr}), 0);
    end
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1 in_valid = $urandom_range(0, 3) != 0;
      x = 16'($urandom); y = 16'($urandom);
      cin = 1'($urandom); sub = 1'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
      if (out_valid) begin
        if (q.size() == 0) chk("rand_spurious", 64'(out_valid), 0);
        else begin
          chk("rand_result", 64'(got16()), 64'(q[0]));
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) q.push_back(model(16, {16'h0, x}, {16'h0, y}, cin, sub));
    end
    @(posedge clk);
    #1 in_valid = 0; out_ready = 1;
    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      @(negedge clk);
      if (out_valid) begin
        chk("drain_result", 64'(got16()), 64'(q[0]));
        void'(q.pop_front());
      end
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 64'(q.size()), 0);
    for (int k = 0; k < 6; k++) e4[k] = model(16, 32'(100 + k), 32'(k), 0, 0);
    i4 = 0; got = 0; blk = -1; t0 = -1; t1 = -1;
    @(posedge clk);
    #1 in_valid = 1; x = 16'd100; y = 16'd0; cin = 0; sub = 0; out_ready = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (!out_ready) chk("bp_hold", 64'(got16()), 64'(e4[0]));
        else begin
          chk("bp_order", 64'(got16()), 64'(e4[got]));
          if (got == 0) t0 = c;
          t1 = c;
          got++;
        end
      end
      if (!in_ready && blk < 0) blk = i4;
      if (in_valid && in_ready) i4++;
      @(posedge clk);
      #1 in_valid = i4 < 6; x = 16'(100 + i4); y = 16'(i4); out_ready = c >= 9;
    end
    @(negedge clk);
    chk("bp_dup", 64'(out_valid), 0);
    chk("bp_block_at", 64'(blk), 4);
    chk("bp_count", 64'(got), 6);
    chk("bp_rate", 64'(t1 - t0), 5);
    out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 in_valid = 1; x = 16'(16'h4000 + k); y = 16'd0;
    end
    @(posedge clk);
    #1 reset = 1; in_valid = 1; x = 16'h5555;
    @(posedge clk);
    #1 reset = 0; in_valid = 0;
    chk("mrst_valid", 64'(out_valid), 0);
    chk("mrst_ready", 64'(in_ready), 1);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("mrst_flushed", 64'(seen), 0);
    for (int t = 0; t < 400; t++) begin
      @(posedge clk);
      #1 b_valid = (t < 380) && ($urandom_range(0, 1) == 1);
      b_x = $urandom; b_y = $urandom; b_cin = 1'($urandom); b_sub = 1'($urandom);
      hv[t] = b_valid;
      hr[t] = model(32, b_x, b_y, b_cin, b_sub);
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        int s;
        logic ev;
        s = (g == 0) ? 1 : (g == 1) ? 2 : 8;
        ev = (t >= s) ? hv[t-s] : 1'b0;
        chk($sformatf("sw%0d_ready", s), 64'(b_ir[g]), 1);
        chk($sformatf("sw%0d_valid", s), 64'(b_ov[g]), 64'(ev));
        if (ev) chk($sformatf("sw%0d_result", s), 64'(got32(g)), 64'(hr[t-s]));
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/adder_pipe.md
ADDER_PIPE -- requirements
Module: adder_pipe

Interface
REQ-001 The block SHALL take parameter WIDTH, default 16, giving the operand and sum width in bits.
REQ-002 The block SHALL take parameter STAGES, default 4, giving the pipeline depth; WIDTH mod STAGES SHALL be 0, and CHUNK = WIDTH/STAGES.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port in_valid, input, 1 bit: an operand set is offered.
REQ-006 Port in_ready, output, 1 bit: the block accepts the operand set this cycle.
REQ-007 Port x, input, WIDTH bits: operand A.
REQ-008 Port y, input, WIDTH bits: operand B.
REQ-009 Port cin, input, 1 bit: carry-in, used only when sub=0.
REQ-010 Port sub, input, 1 bit: 0 selects x+y+cin; 1 selects x-y.
REQ-011 Port out_valid, output, 1 bit: the result fields are valid.
REQ-012 Port out_ready, input, 1 bit: downstream accepts the result.
REQ-013 Port sum, output, WIDTH bits: result.
REQ-014 Port cout, output, 1 bit: carry out of bit WIDTH-1.
REQ-015 Port ovf, output, 1 bit: two's-complement signed overflow.
REQ-016 Port zr, output, 1 bit: sum equals 0.
REQ-017 Port ng, output, 1 bit: sum[WIDTH-1].

Function
REQ-018 A transfer in SHALL occur on a cycle with in_valid=1 and in_ready=1; a transfer out SHALL occur on a cycle with out_valid=1 and out_ready=1.
REQ-019 When sub=1, the block SHALL compute x + ~y + 1 and ignore cin; cout=1 then means no borrow.
REQ-020 Stage k (0..STAGES-1) SHALL add bits [k*CHUNK +: CHUNK] using the carry registered by stage k-1; stage 0 SHALL use cin, or 1 when sub=1.
REQ-021 Each stage register SHALL hold: a valid bit, the completed low sum chunks, the unconsumed high operand bits (y already inverted when sub=1), and the chunk carry.
REQ-022 The carry chain within a chunk SHALL be combinational ripple; no combinational path SHALL cross a stage register.
REQ-023 Latency SHALL be STAGES cycles from an input transfer to out_valid=1 for that operand set, with no stalls.
REQ-024 Throughput SHALL be one result per cycle while out_ready=1.
REQ-025 Stage k SHALL advance when stage k is empty or stage k+1 advances; the last stage SHALL advance when it is empty or out_ready=1.
REQ-026 in_ready SHALL equal the stage-0 advance condition; in_ready SHALL NOT depend combinationally on in_valid.
REQ-027 While out_valid=1 and out_ready=0, sum, cout, ovf, zr and ng SHALL hold stable and no in-flight operand set SHALL be lost or reordered.
REQ-028 A full pipeline with out_ready=0 SHALL give in_ready=0; with out_ready=1 on a full pipeline, input and output transfers SHALL both occur in the same cycle.
REQ-029 ovf SHALL equal (carry into bit WIDTH-1) XOR cout.
REQ-030 zr and ng SHALL be derived from the final registered sum only.
REQ-031 Results SHALL wrap modulo 2^WIDTH; no saturation.

Reset
REQ-032 With reset=1 at a clock edge, every stage valid bit SHALL clear, so out_valid=0 and in_ready=1 in the following cycle.
REQ-033 After reset, sum, cout, ovf, zr and ng SHALL be 0; zr SHALL be forced 0 while out_valid=0.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight operand sets, and any input offered in the same cycle SHALL NOT be accepted.

Structure
REQ-035 A shared package hack_arith_pkg SHALL hold the default WIDTH (16) and STAGES (4) constants and a STAGES-divides-WIDTH check function.
REQ-036 One sub-module, adder_chunk (CHUNK-bit ripple adder with cin, sum, cout and carry into its MSB), SHALL be instantiated once per stage.

Verification
REQ-037 The bench SHALL cover the following directed scenarios:
- Scenario 1 (basic add): reset, then x=8, y=8, cin=0, sub=0, out_ready=1 -> after 4 cycles out_valid=1, sum=16, cout=0, ovf=0, zr=0, ng=0.
- Scenario 2 (wrap and signed overflow): x=16'hFFFF, y=1, sub=0 -> sum=0, cout=1, zr=1, ovf=0; then x=16'h7FFF, y=1 -> sum=16'h8000, ovf=1, ng=1.
- Scenario 3 (subtract): x=5, y=7, sub=1, cin=1 -> sum=16'hFFFE, cout=0, ng=1; then x=7, y=7, sub=1 -> sum=0, zr=1, cout=1.
- Scenario 4 (backpressure): stream 6 back-to-back sets with out_ready=0 -> in_ready drops after the 4th accept, and the first result holds stable; then raise out_ready -> all 6 results emerge in order, one per cycle, with no duplicates.
- Scenario 5 (reset mid-stream): assert reset with 3 sets in flight -> out_valid=0 in the next cycle, and none of the 3 results ever appears.
- Scenario 6 (parameter sweep): WIDTH=32 with STAGES=1, 2 and 8 -> random add/sub checked against a reference model, with latency equal to STAGES.
